// File: rtl/sap_ctrl_pkg.sv
// Shared opcode and T-state constants for the SAP-style control sequencer.
// Imported by the ring counter and the decode/halt logic.
package sap_ctrl_pkg;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [5:0] T1 = 6'b000001;
  localparam logic [5:0] T2 = 6'b000010;
  localparam logic [5:0] T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000;
  localparam logic [5:0] T5 = 6'b010000;
  localparam logic [5:0] T6 = 6'b100000;

  function automatic logic is_onehot(input logic [5:0] v);
    return (v != 6'd0) && ((v & (v - 6'd1)) == 6'd0);
  endfunction

endpackage

// File: rtl/ring_counter.sv
// Six-state one-hot T-state ring with hold and self-recovery.
// Any non-one-hot value falls back to T1 on the next edge.
module ring_counter
  import sap_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       hold,
  output logic [5:0] ring_o
);

  logic [5:0] ring_q;
  logic [5:0] ring_d;

  always_comb begin
    ring_d = ring_q;
    if (!is_onehot(ring_q)) begin
      ring_d = T1;
    end else if (!hold) begin
      ring_d = {ring_q[4:0], ring_q[5]};
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ring_q <= T1;
    end else begin
      ring_q <= ring_d;
    end
  end

  assign ring_o = ring_q;

endmodule

// File: rtl/control_sequencer.sv
// Control word decode and halt latch driven by the T-state ring.
// Outputs are combinational from t_state, opcode and halted.
module control_sequencer
  import sap_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] opcode,
  output logic       pc_inc,
  output logic       pc_out,
  output logic       mar_wa,
  output logic       ram_oe,
  output logic       ir_load,
  output logic       ir_out,
  output logic       acc_load,
  output logic       acc_out,
  output logic       breg_load,
  output logic       alu_sub,
  output logic       alu_out,
  output logic       out_load,
  output logic       halted,
  output logic [5:0] t_state
);

  logic halted_q;
  logic halted_d;
  logic is_lda;
  logic is_arith;
  logic is_out;

  ring_counter u_ring (
    .clk    (clk),
    .clr    (clr),
    .hold   (halted_q),
    .ring_o (t_state)
  );

  assign is_lda   = (opcode == OP_LDA);
  assign is_arith = (opcode == OP_ADD) || (opcode == OP_SUB);
  assign is_out   = (opcode == OP_OUT);

  // Halt takes effect on the edge that ends T4; ring then sits in T5.
  always_comb begin
    halted_d = halted_q;
    if ((t_state == T4) && (opcode == OP_HLT)) begin
      halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  assign halted = halted_q;

  always_comb begin
    pc_inc    = 1'b0;
    pc_out    = 1'b0;
    mar_wa    = 1'b0;
    ram_oe    = 1'b0;
    ir_load   = 1'b0;
    ir_out    = 1'b0;
    acc_load  = 1'b0;
    acc_out   = 1'b0;
    breg_load = 1'b0;
    alu_sub   = 1'b0;
    alu_out   = 1'b0;
    out_load  = 1'b0;
    if (!halted_q) begin
      unique case (t_state)
        T1: begin
          pc_out = 1'b1;
          mar_wa = 1'b1;
        end
        T2: pc_inc = 1'b1;
        T3: begin
          ram_oe  = 1'b1;
          ir_load = 1'b1;
        end
        T4: begin
          if (is_lda || is_arith) begin
            ir_out = 1'b1;
            mar_wa = 1'b1;
          end else if (is_out) begin
            acc_out  = 1'b1;
            out_load = 1'b1;
          end
        end
        T5: begin
          if (is_lda || is_arith) begin
            ram_oe    = 1'b1;
            acc_load  = is_lda;
            breg_load = is_arith;
          end
        end
        T6: begin
          if (is_arith) begin
            alu_out  = 1'b1;
            acc_load = 1'b1;
            alu_sub  = (opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: directed instructions,
// halt/clear scenarios and a random run with per-cycle invariants.
module tb_control_sequencer;

  logic       clk;
  logic       clr;
  logic [3:0] opcode;
  logic       pc_inc, pc_out, mar_wa, ram_oe, ir_load, ir_out;
  logic       acc_load, acc_out, breg_load, alu_sub, alu_out, out_load;
  logic       halted;
  logic [5:0] t_state;

  control_sequencer dut (
    .clk       (clk),
    .clr       (clr),
    .opcode    (opcode),
    .pc_inc    (pc_inc),
    .pc_out    (pc_out),
    .mar_wa    (mar_wa),
    .ram_oe    (ram_oe),
    .ir_load   (ir_load),
    .ir_out    (ir_out),
    .acc_load  (acc_load),
    .acc_out   (acc_out),
    .breg_load (breg_load),
    .alu_sub   (alu_sub),
    .alu_out   (alu_out),
    .out_load  (out_load),
    .halted    (halted),
    .t_state   (t_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [12:0] C_PCINC = 13'h1000;
  localparam logic [12:0] C_PCOUT = 13'h0800;
  localparam logic [12:0] C_MARWA = 13'h0400;
  localparam logic [12:0] C_RAMOE = 13'h0200;
  localparam logic [12:0] C_IRLD  = 13'h0100;
  localparam logic [12:0] C_IROUT = 13'h0080;
  localparam logic [12:0] C_ACCLD = 13'h0040;
  localparam logic [12:0] C_ACCO  = 13'h0020;
  localparam logic [12:0] C_BRLD  = 13'h0010;
  localparam logic [12:0] C_SUB   = 13'h0008;
  localparam logic [12:0] C_ALUO  = 13'h0004;
  localparam logic [12:0] C_OUTLD = 13'h0002;
  localparam logic [12:0] C_HALT  = 13'h0001;
  localparam logic [12:0] C_NONE  = 13'h0000;
  localparam logic [12:0] CT1 = C_PCOUT | C_MARWA;

  localparam logic [5:0] S1 = 6'b000001;
  localparam logic [5:0] S2 = 6'b000010;
  localparam logic [5:0] S3 = 6'b000100;
  localparam logic [5:0] S4 = 6'b001000;
  localparam logic [5:0] S5 = 6'b010000;
  localparam logic [5:0] S6 = 6'b100000;

  typedef struct {
    string      nm;
    logic [5:0] t;
    logic [12:0] c;
  } exp_t;

  exp_t q[$];
  int   checks;
  int   failures;
  logic chk_en;

  logic [12:0] act;
  logic [4:0]  bus;
  assign act = {pc_inc, pc_out, mar_wa, ram_oe, ir_load, ir_out, acc_load,
                acc_out, breg_load, alu_sub, alu_out, out_load, halted};
  assign bus = {pc_out, ram_oe, ir_out, acc_out, alu_out};

  initial begin
    checks   = 0;
    failures = 0;
    chk_en   = 1'b0;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      exp_t e;
      checks++;
      if (!$onehot0(bus)) begin
        failures++;
        $display("FAIL bus_onehot0: bus=%b t_state=%b", bus, t_state);
      end
      checks++;
      if (!$onehot(t_state)) begin
        failures++;
        $display("FAIL t_state_onehot: t_state=%b", t_state);
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (t_state !== e.t || act !== e.c) begin
          failures++;
          $display("FAIL %s: got t_state=%b ctrl=%b, expected t_state=%b ctrl=%b",
                   e.nm, t_state, act, e.t, e.c);
        end
      end
    end
  end

  task automatic step(input string nm, input logic [5:0] t, input logic [12:0] c);
    q.push_back('{nm: nm, t: t, c: c});
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input string nm, input logic [3:0] op,
                           input logic [12:0] c4, input logic [12:0] c5,
                           input logic [12:0] c6);
    opcode = op;
    step({nm, "_t1"}, S1, CT1);
    step({nm, "_t2"}, S2, C_PCINC);
    step({nm, "_t3"}, S3, C_RAMOE | C_IRLD);
    step({nm, "_t4"}, S4, c4);
    step({nm, "_t5"}, S5, c5);
    step({nm, "_t6"}, S6, c6);
  endtask

  logic [3:0] ops [7];
  logic [3:0] op;
  logic       pulse;
  int         k;

  initial begin
    ops = '{4'h0, 4'h1, 4'h2, 4'he, 4'hf, 4'h7, 4'h3};
    clr    = 1'b1;
    opcode = 4'h0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    step("reset_hold", S1, CT1);
    clr = 1'b0;

    run_instr("lda", 4'h0, C_IROUT | C_MARWA, C_RAMOE | C_ACCLD, C_NONE);
    run_instr("add", 4'h1, C_IROUT | C_MARWA, C_RAMOE | C_BRLD, C_ALUO | C_ACCLD);
    run_instr("sub", 4'h2, C_IROUT | C_MARWA, C_RAMOE | C_BRLD,
              C_ALUO | C_ACCLD | C_SUB);
    run_instr("out", 4'he, C_ACCO | C_OUTLD, C_NONE, C_NONE);
    run_instr("undef", 4'h7, C_NONE, C_NONE, C_NONE);
    run_instr("lda2", 4'h0, C_IROUT | C_MARWA, C_RAMOE | C_ACCLD, C_NONE);

    opcode = 4'hf;
    step("hlt_t1", S1, CT1);
    step("hlt_t2", S2, C_PCINC);
    step("hlt_t3", S3, C_RAMOE | C_IRLD);
    step("hlt_t4", S4, C_NONE);
    for (int i = 0; i < 21; i++) step("halted_hold", S5, C_HALT);

    clr = 1'b1;
    step("clr_while_halted", S1, CT1);
    clr = 1'b0;
    opcode = 4'h1;
    step("post_clr_t1", S1, CT1);
    step("post_clr_t2", S2, C_PCINC);
    step("add_t3", S3, C_RAMOE | C_IRLD);
    step("add_t4", S4, C_IROUT | C_MARWA);
    clr = 1'b1;
    step("clr_mid_instr", S1, CT1);
    clr = 1'b0;
    run_instr("sub2", 4'h2, C_IROUT | C_MARWA, C_RAMOE | C_BRLD,
              C_ALUO | C_ACCLD | C_SUB);

    for (int i = 0; i < 1000; i++) begin
      op     = ops[$urandom_range(0, 6)];
      opcode = op;
      pulse  = ($urandom_range(0, 19) == 0);
      k      = $urandom_range(0, 5);
      for (int s = 0; s < 6; s++) begin
        if (pulse && s == k) begin
          clr = 1'b1;
          step("rnd_clr", S1, CT1);
          clr = 1'b0;
          break;
        end
        if (s == 0) begin
          step("rnd_t1", S1, CT1);
        end else begin
          @(posedge clk);
          #1;
        end
      end
      if (op == 4'hf && !pulse) begin
        clr = 1'b1;
        step("rnd_hlt_clr", S1, CT1);
        clr = 1'b0;
      end
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
